alu_op_sequencer: RTL and testbench

- Issue/retire stage wrapped around the combinational `alu` datapath.
- Accepts ALU commands over a valid/ready handshake and registers the operands onto the ALU input ports.
- Captures the ALU result and flags one cycle later and presents them downstream over a second valid/ready handshake.
- Keeps a persistent NZCV flag register so multi-word arithmetic can chain the carry into the next command.

---
 rtl/alu_op_sequencer.sv | 118 +++++++++++
 tb/tb_alu_op_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Issue/retire stage around a combinational ALU: registers commands onto the ALU inputs,
// captures result/NZCV one cycle later, keeps persistent flags. Optional op_count via ALU_SEQ_STATS_EN.
module alu_op_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [1:0]       cmd_carry_sel,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout,
  input  logic             alu_overflow,
  input  logic             alu_negative,
  input  logic             alu_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_y,
  output logic [3:0]       res_flags,
`ifdef ALU_SEQ_STATS_EN
  output logic [15:0]      op_count,
`endif
  output logic [3:0]       flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;
  logic   accept, capture, retire;
  logic   carry_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Handshake outputs decode straight from the state register, so reset drives them immediately.
  always_comb begin
    state_next = IDLE;
    cmd_ready  = 1'b0;
    res_valid  = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready  = 1'b1;
        accept     = cmd_valid;
        state_next = cmd_valid ? EXEC : IDLE;
      end
      EXEC: begin
        capture    = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        res_valid  = 1'b1;
        retire     = res_ready;
        state_next = res_ready ? IDLE : DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    carry_in = 1'b0;
    case (cmd_carry_sel)
      2'b01:   carry_in = 1'b1;
      2'b10:   carry_in = flags[1];
      default: carry_in = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cin    <= 1'b0;
      res_y      <= '0;
      res_flags  <= '0;
      flags      <= '0;
    end else begin
      if (accept) begin
        alu_opcode <= cmd_opcode;
        alu_a      <= cmd_a;
        alu_b      <= cmd_b;
        alu_cin    <= carry_in;
      end
      if (capture) begin
        res_y     <= alu_y;
        res_flags <= {alu_negative, alu_zero, alu_cout, alu_overflow};
        flags     <= {alu_negative, alu_zero, alu_cout, alu_overflow};
      end
    end
  end

`ifdef ALU_SEQ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         op_count <= '0;
    else if (retire && op_count != '1) op_count <= op_count + 16'd1;
  end
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: behavioural ALU, table vectors, corner sequences, random traffic.
module tb_alu_op_sequencer;
  localparam int W = 4;

  logic         clk, rst;
  logic         cmd_valid, cmd_ready;
  logic [3:0]   cmd_opcode;
  logic [W-1:0] cmd_a, cmd_b;
  logic [1:0]   cmd_carry_sel;
  logic [3:0]   alu_opcode;
  logic [W-1:0] alu_a, alu_b;
  logic         alu_cin;
  logic [W-1:0] alu_y;
  logic         alu_cout, alu_overflow, alu_negative, alu_zero;
  logic         res_valid, res_ready;
  logic [W-1:0] res_y;
  logic [3:0]   res_flags, flags;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0]  op_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic         force_c = 1'b0;
  logic [3:0]   mdl_flags = '0;
  int unsigned  mdl_count = 0;

  alu_op_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_carry_sel(cmd_carry_sel),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_y(alu_y), .alu_cout(alu_cout), .alu_overflow(alu_overflow),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_y(res_y), .res_flags(res_flags),
`ifdef ALU_SEQ_STATS_EN
    .op_count(op_count),
`endif
    .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU: 0 add, 1 subtract-with-borrow (cout = borrow), 2 and, 3 or, 4 xor, else pass a.
  function automatic logic [W+3:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic cin);
    logic [W:0]   s;
    logic [W-1:0] y;
    logic         c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        y = s[W-1:0]; c = s[W];
        v = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
      end
      4'd1: begin
        s = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
        y = s[W-1:0]; c = s[W];
        v = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
      end
      4'd2:    y = a & b;
      4'd3:    y = a | b;
      4'd4:    y = a ^ b;
      default: y = a;
    endcase
    return {y, y[W-1], (y == '0), c, v};
  endfunction

  logic [W+3:0] alu_out;
  always_comb alu_out = alu_fn(alu_opcode, alu_a, alu_b, alu_cin);
  assign alu_y        = alu_out[W+3:4];
  assign alu_negative = alu_out[3];
  assign alu_zero     = alu_out[2];
  assign alu_cout     = alu_out[1] | force_c;
  assign alu_overflow = alu_out[0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full transaction from IDLE; hold = DONE cycles with res_ready low, junk = cmd_valid driven meanwhile.
  task automatic run_cmd(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] sel, input logic [W-1:0] ey, input logic [3:0] efl,
                         input logic ecin, input logic fc, input int hold, input logic junk);
    cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_carry_sel = sel; cmd_valid = 1'b1;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    force_c = fc;
    chk("alu_opcode", alu_opcode, op);
    chk("alu_a", alu_a, a);
    chk("alu_b", alu_b, b);
    chk("alu_cin", alu_cin, ecin);
    chk("cmd_ready_exec", cmd_ready, 0);
    chk("res_valid_exec", res_valid, 0);
    @(posedge clk); #1;
    force_c = 1'b0;
    mdl_flags = efl;
    chk("res_valid_done", res_valid, 1);
    chk("res_y", res_y, ey);
    chk("res_flags", res_flags, efl);
    chk("flags", flags, efl);
    for (int i = 0; i < hold; i++) begin
      res_ready = 1'b0;
      if (junk) begin
        cmd_valid = 1'b1; cmd_opcode = 4'($urandom); cmd_a = W'($urandom);
        cmd_b = W'($urandom); cmd_carry_sel = 2'($urandom);
      end
      @(posedge clk); #1;
      chk("hold_res_valid", res_valid, 1);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_res_y", res_y, ey);
      chk("hold_alu_a", alu_a, a);
      chk("hold_alu_b", alu_b, b);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    cmd_valid = 1'b0;
    if (mdl_count < 32'hFFFF) mdl_count++;
    chk("retire_res_valid", res_valid, 0);
    chk("retire_cmd_ready", cmd_ready, 1);
    chk("retire_alu_a_kept", alu_a, a);
  endtask

  task automatic run_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] sel, input int hold, input logic junk);
    logic         cin;
    logic [W+3:0] r;
    cin = (sel == 2'b01) ? 1'b1 : (sel == 2'b10) ? mdl_flags[1] : 1'b0;
    r = alu_fn(op, a, b, cin);
    run_cmd(op, a, b, sel, r[W+3:4], r[3:0], cin, 1'b0, hold, junk);
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic [1:0]   sel;
    logic [W-1:0] y;
    logic [3:0]   fl;
    logic         cin;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'd0, 4'h1, 4'h1, 2'd0, 4'h2, 4'b0000, 1'b0};
    vecs[1] = '{4'd1, 4'h1, 4'h1, 2'd0, 4'h0, 4'b0100, 1'b0};
    vecs[2] = '{4'd0, 4'hF, 4'h1, 2'd0, 4'h0, 4'b0110, 1'b0};
    vecs[3] = '{4'd0, 4'h2, 4'h3, 2'd2, 4'h6, 4'b0000, 1'b1};
    vecs[4] = '{4'd0, 4'h7, 4'h1, 2'd1, 4'h9, 4'b1001, 1'b1};
    vecs[5] = '{4'd1, 4'h0, 4'h1, 2'd0, 4'hF, 4'b1010, 1'b0};
    vecs[6] = '{4'd2, 4'hC, 4'hA, 2'd3, 4'h8, 4'b1000, 1'b0};
    vecs[7] = '{4'd4, 4'h5, 4'h5, 2'd2, 4'h0, 4'b0100, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_opcode = '0; cmd_a = '0; cmd_b = '0; cmd_carry_sel = '0;
    #3;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_cin", alu_cin, 0);
    chk("rst_res_y", res_y, 0);
    chk("rst_flags", flags, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].y, vecs[i].fl,
              vecs[i].cin, 1'b0, 0, 1'b0);
`ifdef ALU_SEQ_STATS_EN
    chk("op_count_8", op_count, 8);
`endif

    // Carry chaining with a forced carry-out, then reserved carry_sel.
    run_cmd(4'd0, 4'h1, 4'h1, 2'd0, 4'h2, 4'b0010, 1'b0, 1'b1, 0, 1'b0);
    run_cmd(4'd0, 4'h3, 4'h4, 2'd2, 4'h8, 4'b1001, 1'b1, 1'b0, 0, 1'b0);
    run_cmd(4'd0, 4'h3, 4'h4, 2'd3, 4'h7, 4'b0000, 1'b0, 1'b0, 0, 1'b0);

    // Backpressure with competing commands, then immediate next accept.
    run_cmd(4'd0, 4'h5, 4'h6, 2'd0, 4'hB, 4'b1001, 1'b0, 1'b0, 5, 1'b1);
    run_cmd(4'd3, 4'h5, 4'h2, 2'd2, 4'h7, 4'b0000, 1'b0, 1'b0, 0, 1'b0);

    // Reset while a command is in EXEC.
    run_cmd(4'd1, 4'h0, 4'h1, 2'd0, 4'hF, 4'b1010, 1'b0, 1'b0, 0, 1'b0);
    cmd_opcode = 4'd0; cmd_a = 4'hF; cmd_b = 4'hF; cmd_carry_sel = 2'd1; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_flags", flags, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_alu_a", alu_a, 0);
    mdl_flags = '0; mdl_count = 0;
`ifdef ALU_SEQ_STATS_EN
    chk("midrst_op_count", op_count, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_rst_res_valid", res_valid, 0);
    end

    for (int i = 0; i < 40; i++)
      run_model(4'($urandom_range(0, 5)), W'($urandom), W'($urandom), 2'($urandom_range(0, 3)),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
`ifdef ALU_SEQ_STATS_EN
    chk("op_count_random", op_count, mdl_count);
    force dut.op_count = 16'hFFFE;
    #1;
    release dut.op_count;
    mdl_count = 32'hFFFE;
    for (int i = 0; i < 3; i++)
      run_model(4'($urandom_range(0, 5)), W'($urandom), W'($urandom), 2'($urandom_range(0, 3)), 0, 1'b0);
    chk("op_count_sat", op_count, 16'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
